// File: rtl/maze_pkg.sv
// Shared constants, encodings and probe offset table for the maze collision probe.
// One map tile is 8x8 px; the map is 80x60 tiles (640x480 px).
package maze_pkg;

  localparam int          TILE_SHIFT = 3;
  localparam logic [31:0] MAP_COLS   = 32'd80;
  localparam logic [31:0] MAP_ROWS   = 32'd60;
  localparam logic [31:0] SPRITE_W   = 32'd24;
  localparam logic [31:0] SPRITE_H   = 32'd24;
  localparam int          ADDR_W     = 13;
  localparam logic [31:0] MAP_W_PX   = MAP_COLS << TILE_SHIFT;
  localparam logic [31:0] MAP_H_PX   = MAP_ROWS << TILE_SHIFT;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_LATCH  = 2'd0,
    ST_PROBE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Edge sample points: both ends of the edge plus two interior points 8 px apart.
  function automatic logic [31:0] probe_off(input logic [1:0] sel, input logic [31:0] span);
    case (sel)
      2'd0:    probe_off = 32'd0;
      2'd1:    probe_off = 32'd8;
      2'd2:    probe_off = 32'd16;
      default: probe_off = span - 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/maze_probe_addr.sv
// Maps (latched position, probe index) to a map tile address, an out-of-bounds flag
// and the edge direction the probe belongs to. Purely combinational.
module maze_probe_addr
  import maze_pkg::*;
(
  input  logic [31:0]       lx,
  input  logic [31:0]       ly,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr,
  output logic              oob,
  output dir_t              dir
);

  logic [31:0]       px;
  logic [31:0]       py;
  logic [ADDR_W-1:0] lin;

  // probe point selection, bounds test and tile index
  always_comb begin
    dir = dir_t'(k[3:2]);
    px  = lx;
    py  = ly;
    case (dir)
      DIR_UP: begin
        px = lx + probe_off(k[1:0], SPRITE_W);
        py = ly - 32'd1;
      end
      DIR_RIGHT: begin
        px = lx + SPRITE_W;
        py = ly + probe_off(k[1:0], SPRITE_H);
      end
      DIR_DOWN: begin
        px = lx + probe_off(k[1:0], SPRITE_W);
        py = ly + SPRITE_H;
      end
      DIR_LEFT: begin
        px = lx - 32'd1;
        py = ly + probe_off(k[1:0], SPRITE_H);
      end
      default: begin
        px = lx;
        py = ly;
      end
    endcase
    // wrapped coordinates (0 - 1) land far above the map and read as out of bounds
    oob  = (px >= MAP_W_PX) || (py >= MAP_H_PX);
    lin  = ADDR_W'(py >> TILE_SHIFT) * ADDR_W'(MAP_COLS) + ADDR_W'(px >> TILE_SHIFT);
    if (oob) begin
      addr = '0;
    end else begin
      addr = lin;
    end
  end

endmodule

// File: rtl/maze_collision_probe.sv
// Per-player wall-collision probe: latches the sprite position, reads 16 edge tiles
// one per cycle through a 1-cycle-latency map port, then commits 4 flags atomically.
module maze_collision_probe
  import maze_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       player_x,
  input  logic [31:0]       player_y,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_wall,
  output logic              collision_up,
  output logic              collision_right,
  output logic              collision_down,
  output logic              collision_left,
  output logic              collision_valid,
  output logic              sweep_done
);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [31:0]       lx;
  logic [31:0]       ly;
  logic [3:0]        acc;
  logic [3:0]        flags;
  logic              issue;
  logic [31:0]       probe_x;
  logic [31:0]       probe_y;
  logic [3:0]        probe_k;
  logic [ADDR_W-1:0] probe_addr;
  logic              probe_oob;
  dir_t              probe_dir;
  logic              addr_live;
  logic              addr_oob;
  dir_t              addr_dir;
  logic              wall_live;
  logic              wall_oob;
  dir_t              wall_dir;

  // The address for probe k is registered on the edge entering PROBE k, so the
  // generator looks one probe ahead (and at the raw player position while latching).
  maze_probe_addr u_addr (
    .lx   (probe_x),
    .ly   (probe_y),
    .k    (probe_k),
    .addr (probe_addr),
    .oob  (probe_oob),
    .dir  (probe_dir)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_LATCH;
    end else begin
      state <= state_next;
    end
  end

  // next state, probe issue and look-ahead probe selection
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    probe_x    = lx;
    probe_y    = ly;
    probe_k    = cnt + 4'd1;
    case (state)
      ST_LATCH: begin
        probe_x = player_x;
        probe_y = player_y;
        probe_k = 4'd0;
        if (enable) begin
          issue      = 1'b1;
          state_next = ST_PROBE;
        end else begin
          state_next = ST_LATCH;
        end
      end
      ST_PROBE: begin
        if (cnt == 4'd15) begin
          state_next = ST_DRAIN;
        end else begin
          issue      = 1'b1;
          state_next = ST_PROBE;
        end
      end
      ST_DRAIN:  state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_LATCH;
      default:   state_next = ST_LATCH;
    endcase
  end

  // probe pipeline, accumulators and committed outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt             <= 4'd0;
      lx              <= 32'd0;
      ly              <= 32'd0;
      acc             <= 4'b0000;
      map_addr        <= '0;
      addr_live       <= 1'b0;
      addr_oob        <= 1'b0;
      addr_dir        <= DIR_UP;
      wall_live       <= 1'b0;
      wall_oob        <= 1'b0;
      wall_dir        <= DIR_UP;
      flags           <= 4'b1111;
      collision_valid <= 1'b0;
      sweep_done      <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      addr_live  <= issue;
      wall_live  <= addr_live;
      wall_oob   <= addr_oob;
      wall_dir   <= addr_dir;
      if (issue) begin
        map_addr <= probe_addr;
        addr_oob <= probe_oob;
        addr_dir <= probe_dir;
      end
      // an out-of-bounds probe counts as a wall whatever the map returns
      if (wall_live) begin
        acc[wall_dir] <= acc[wall_dir] | wall_oob | map_wall;
      end
      if (state == ST_LATCH) begin
        cnt <= 4'd0;
        if (enable) begin
          lx  <= player_x;
          ly  <= player_y;
          acc <= 4'b0000;
        end
      end else if (state == ST_PROBE) begin
        cnt <= cnt + 4'd1;
      end
      if (state == ST_COMMIT) begin
        flags           <= acc;
        collision_valid <= 1'b1;
        sweep_done      <= 1'b1;
      end
    end
  end

  assign collision_up    = flags[DIR_UP];
  assign collision_right = flags[DIR_RIGHT];
  assign collision_down  = flags[DIR_DOWN];
  assign collision_left  = flags[DIR_LEFT];

endmodule

// File: tb/tb_maze_collision_probe.sv
// Self-checking bench: 4800x1 map ROM with registered read, expected flag sets queued
// when a position is driven and compared whenever the probe commits.
module tb_maze_collision_probe;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] player_x;
  logic [31:0] player_y;
  logic [12:0] map_addr;
  logic        map_wall = 1'b0;
  logic        collision_up;
  logic        collision_right;
  logic        collision_down;
  logic        collision_left;
  logic        collision_valid;
  logic        sweep_done;
  logic [3:0]  flags_obs;

  logic map_rom [0:4799];

  typedef struct {
    string      tag;
    logic [3:0] flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n;

  maze_collision_probe dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .player_x        (player_x),
    .player_y        (player_y),
    .map_addr        (map_addr),
    .map_wall        (map_wall),
    .collision_up    (collision_up),
    .collision_right (collision_right),
    .collision_down  (collision_down),
    .collision_left  (collision_left),
    .collision_valid (collision_valid),
    .sweep_done      (sweep_done)
  );

  always #5 clock = ~clock;

  assign flags_obs = {collision_left, collision_down, collision_right, collision_up};

  always @(posedge clock) begin
    map_wall <= (map_addr < 13'd4800) ? map_rom[map_addr] : 1'b0;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // commit monitor: every sweep_done pulse consumes one queued expectation
  always @(negedge clock) begin
    if (sweep_done) begin
      if (sb_q.size() == 0) begin
        check_value("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_value({mon_e.tag, "_flags"}, 32'(flags_obs), 32'(mon_e.flags));
        check_value({mon_e.tag, "_valid"}, 32'(collision_valid), 32'd1);
      end
    end
  end

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (!sweep_done && cycles < 60);
    if (!sweep_done) check_value({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // called in the cycle a commit is visible; the next latch edge takes the new position
  task automatic sweep(input logic [31:0] x, input logic [31:0] y, input logic [3:0] exp,
                       input string tag);
    int c;
    player_x = x;
    player_y = y;
    sb_q.push_back('{tag, exp});
    wait_done(tag, c);
    check_value({tag, "_period"}, 32'(c), 32'd19);
  endtask

  task automatic idle_check(input string tag, input logic [3:0] hold);
    logic [12:0] a0;
    int moved = 0;
    int dones = 0;
    int drift = 0;
    a0 = map_addr;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (map_addr != a0) moved++;
      if (sweep_done) dones++;
      if (flags_obs != hold) drift++;
    end
    check_value({tag, "_addr_moves"}, 32'(moved), 32'd0);
    check_value({tag, "_dones"}, 32'(dones), 32'd0);
    check_value({tag, "_flag_drift"}, 32'(drift), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    player_x = 32'd260;
    player_y = 32'd240;
    for (int i = 0; i < 4800; i++) map_rom[i] = 1'b0;

    // reset state
    repeat (3) begin
      @(posedge clock);
      #1;
      check_value("rst_flags", 32'(flags_obs), 32'hF);
      check_value("rst_valid", 32'(collision_valid), 32'd0);
      check_value("rst_done", 32'(sweep_done), 32'd0);
    end

    // first sweep latency and steady period, empty map
    sb_q.push_back('{"t1_first", 4'b0000});
    sb_q.push_back('{"t1_second", 4'b0000});
    reset = 1'b0;
    wait_done("t1_first", n);
    check_value("t1_latency", 32'(n), 32'd19);
    wait_done("t1_second", n);
    check_value("t1_period", 32'(n), 32'd19);

    // map boundaries, empty map
    sweep(32'd0,   32'd240, 4'b1000, "t3_left_wrap");
    sweep(32'd616, 32'd240, 4'b0010, "t3_right_edge");
    sweep(32'd260, 32'd456, 4'b0100, "t3_bottom_edge");
    sweep(32'd260, 32'd0,   4'b0001, "t3_top_wrap");

    // position change mid-sweep is ignored until the next latch
    player_x = 32'd260;
    player_y = 32'd240;
    sb_q.push_back('{"t4_old", 4'b0000});
    @(posedge clock);
    repeat (5) @(posedge clock);
    #1;
    player_x = 32'd0;
    sb_q.push_back('{"t4_new", 4'b1000});
    wait_done("t4_old", n);
    check_value("t4_tail", 32'(n), 32'd13);
    wait_done("t4_new", n);
    check_value("t4_period", 32'(n), 32'd19);

    // single wall tile at col 31, row 30 (pixels x 248..255, y 240..247)
    map_rom[30*80+31] = 1'b1;
    sweep(32'd249, 32'd240, 4'b1000, "t2_left_a");
    sweep(32'd256, 32'd240, 4'b1000, "t2_left_b");
    sweep(32'd257, 32'd240, 4'b0000, "t2_clear");
    sweep(32'd225, 32'd240, 4'b0010, "t2_right");
    sweep(32'd249, 32'd217, 4'b1100, "t2_down_left");
    sweep(32'd249, 32'd248, 4'b0001, "t2_up");

    // reset in the middle of a sweep aborts it
    player_x = 32'd260;
    player_y = 32'd456;
    @(posedge clock);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_value("t5_flags", 32'(flags_obs), 32'hF);
    check_value("t5_valid", 32'(collision_valid), 32'd0);
    check_value("t5_addr", 32'(map_addr), 32'd0);
    check_value("t5_done", 32'(sweep_done), 32'd0);
    reset = 1'b0;
    sb_q.delete();
    sb_q.push_back('{"t5_restart", 4'b0100});
    wait_done("t5_restart", n);
    check_value("t5_latency", 32'(n), 32'd19);

    // enable low in LATCH: no activity, flags hold
    enable = 1'b0;
    idle_check("t6_idle", 4'b0100);

    // enable dropped at probe 3: sweep completes, then stalls
    enable   = 1'b1;
    player_x = 32'd0;
    player_y = 32'd240;
    sb_q.push_back('{"t6_finish", 4'b1000});
    @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    enable = 1'b0;
    wait_done("t6_finish", n);
    check_value("t6_tail", 32'(n), 32'd15);
    idle_check("t6_stall", 4'b1000);

    check_value("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
